// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic slave bundle used between the LM32 bus fabric and wb_gpio_irq.
interface wb_gpio_irq_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
      output wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO with per-bit direction, set/clear ports and masked edge interrupts.
// Define WB_GPIO_DEBOUNCE_EN to insert a 3-tick debouncer between synchroniser and DATA_IN.
module wb_gpio_irq #(
   parameter int unsigned GPIO_WIDTH   = 8,
   parameter logic [31:0] DIR_RESET    = 32'h0,
   parameter logic [31:0] OUT_RESET    = 32'h0,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_gpio_irq_if.slave          wb,
   output logic                  irq_o,
   inout  wire  [GPIO_WIDTH-1:0] gpio_io
);
   localparam int W = GPIO_WIDTH;

   logic          access, req, wr, rd;
   logic [2:0]    addr;
   logic [31:0]   bm32;
   logic [W-1:0]  bm_w, wdat_w, lane_w;

   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d, rdata;
   logic [W-1:0]  out_q, out_d;
   logic [W-1:0]  dir_q, dir_d;
   logic [W-1:0]  dirp_q;
   logic [W-1:0]  mask_q, mask_d;
   logic [W-1:0]  edg_q, edg_d;
   logic [W-1:0]  pend_q, pend_d;
   logic [W-1:0]  prev_q;
   logic [W-1:0]  clr, ev;
   logic          irq_q, irq_d;
   logic [W-1:0]  sync_q [SYNC_STAGES];
   logic [W-1:0]  sync_o;
   logic [W-1:0]  data_in;
   logic          unused_bits;

   assign access = wb.wb_cyc_i & wb.wb_stb_i;
   // First cycle of an access is the decode cycle; the ack cycle that follows is idle.
   assign req    = access & ~ack_q;
   assign wr     = req & wb.wb_we_i;
   assign rd     = req & ~wb.wb_we_i;
   assign addr   = wb.wb_adr_i[4:2];
   assign bm32   = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                    {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
   assign bm_w   = bm32[W-1:0];
   assign wdat_w = wb.wb_dat_i[W-1:0];
   assign lane_w = wdat_w & bm_w;

   assign wb.wb_ack_o = access & ack_q;
   assign wb.wb_dat_o = dat_q;
   assign irq_o       = irq_q;
   assign sync_o      = sync_q[SYNC_STAGES-1];

   for (genvar i = 0; i < W; i++) begin : g_pin
      assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

`ifdef WB_GPIO_DEBOUNCE_EN
   localparam int PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

   logic [PW-1:0]      pre_q, pre_d;
   logic               tick;
   logic [W-1:0]       db_q, db_d;
   logic [W-1:0]       smp_q, smp_d;
   logic [W-1:0][1:0]  cnt_q, cnt_d;

   assign tick    = (pre_q == PW'(DEBOUNCE_DIV - 1));
   assign pre_d   = tick ? '0 : pre_q + 1'b1;
   assign data_in = db_q;

   // cnt counts consecutive ticks that saw the same new value; the third one commits it.
   always_comb begin
      db_d  = db_q;
      smp_d = smp_q;
      cnt_d = cnt_q;
      if (tick) begin
         smp_d = sync_o;
         for (int i = 0; i < W; i++) begin
            if (sync_o[i] == db_q[i]) begin
               cnt_d[i] = 2'd0;
            end else if (sync_o[i] != smp_q[i]) begin
               cnt_d[i] = 2'd1;
            end else if (cnt_q[i] == 2'd2) begin
               db_d[i]  = sync_o[i];
               cnt_d[i] = 2'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
         db_q  <= '0;
         smp_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         db_q  <= db_d;
         smp_q <= smp_d;
         cnt_q <= cnt_d;
      end
   end

   assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, bm32};
`else
   logic unused_div;

   assign data_in     = sync_o;
   assign unused_div  = ^{32'(DEBOUNCE_DIV)};
   assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, bm32};
`endif

   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      edg_d  = edg_q;
      clr    = '0;
      if (wr) begin
         case (addr)
            3'd1:    out_d  = (out_q  & ~bm_w) | lane_w;
            3'd2:    dir_d  = (dir_q  & ~bm_w) | lane_w;
            3'd3:    mask_d = (mask_q & ~bm_w) | lane_w;
            3'd4:    edg_d  = (edg_q  & ~bm_w) | lane_w;
            3'd5:    clr    = lane_w;
            3'd6:    out_d  = out_q | lane_w;
            3'd7:    out_d  = out_q & ~lane_w;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         3'd0:    rdata = 32'(data_in);
         3'd1:    rdata = 32'(out_q);
         3'd2:    rdata = 32'(dir_q);
         3'd3:    rdata = 32'(mask_q);
         3'd4:    rdata = 32'(edg_q);
         3'd5:    rdata = 32'(pend_q);
         default: rdata = '0;
      endcase
   end

   // History always tracks DATA_IN, and a bit must have been an input last cycle too,
   // so a direction change never compares against a stale sample.
   assign ev     = ~dir_q & ~dirp_q &
                   ((edg_q & data_in & ~prev_q) | (~edg_q & ~data_in & prev_q));
   assign pend_d = (pend_q & ~clr) | ev;
   assign irq_d  = |(pend_q & mask_q);
   assign ack_d  = req;
   assign dat_d  = rd ? rdata : dat_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         out_q  <= OUT_RESET[W-1:0];
         dir_q  <= DIR_RESET[W-1:0];
         dirp_q <= DIR_RESET[W-1:0];
         mask_q <= '0;
         edg_q  <= '0;
         pend_q <= '0;
         prev_q <= '0;
         irq_q  <= 1'b0;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         out_q  <= out_d;
         dir_q  <= dir_d;
         dirp_q <= dir_q;
         mask_q <= mask_d;
         edg_q  <= edg_d;
         pend_q <= pend_d;
         prev_q <= data_in;
         irq_q  <= irq_d;
         sync_q[0] <= gpio_io;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: read expectations queued at issue, checked at ack.
// Build with WB_GPIO_DEBOUNCE_EN to exercise the debouncer instead of exact edge latency.
module tb_wb_gpio_irq;
   localparam int SYNC   = 2;
   localparam int SETTLE = 40;

   logic        clk;
   logic        rst;
   logic        irq;
   logic [7:0]  tb_en;
   logic [7:0]  tb_val;
   wire  [7:0]  gpio;
   int          n_tests;
   int          n_fail;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   wb_gpio_irq_if bus ();

   wb_gpio_irq #(
      .GPIO_WIDTH   (8),
      .DIR_RESET    (32'hF0),
      .OUT_RESET    (32'h50),
      .SYNC_STAGES  (SYNC),
      .DEBOUNCE_DIV (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wb      (bus),
      .irq_o   (irq),
      .gpio_io (gpio)
   );

   for (genvar i = 0; i < 8; i++) begin : g_drv
      assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after one idle cycle.
   task automatic xfer(input string tag, input logic we, input logic [2:0] reg_a,
                       input logic [31:0] wdat, input logic [3:0] sel);
      int n;
      bus.wb_adr_i = {27'h0, reg_a, 2'b00};
      bus.wb_dat_i = wdat;
      bus.wb_we_i  = we;
      bus.wb_sel_i = sel;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.wb_ack_o && n < 8);
      chk({tag, "_ack_lat"}, n, 1);
      if (!we) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
         end else begin
            chk(tag_q.pop_front(), bus.wb_dat_o, exp_q.pop_front());
         end
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] sel = 4'b1111);
      xfer(tag, 1'b1, a, d, sel);
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      xfer(tag, 1'b0, a, 32'h0, 4'b1111);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      tb_en   = 8'h0F;
      tb_val  = 8'h00;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_sel_i = '0;
      cyc(3);
      rst = 1'b1;
      cyc(1);

      chk("rst_irq", irq, 0);
      chk("rst_ack", bus.wb_ack_o, 0);
      chk("rst_dat", bus.wb_dat_o, 0);
      chk("rst_pins_hi", gpio[7:4], 4'h5);

      // Reset during a live transfer must drop ack asynchronously.
      bus.wb_adr_i = 32'h8;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      cyc(1);
      chk("mid_ack_pre", bus.wb_ack_o, 1);
      rst = 1'b0;
      #1;
      chk("mid_ack_rst", bus.wb_ack_o, 0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      chk("mid_dat_rst", bus.wb_dat_o, 0);

      // Continuous strobe: ack pulses every other cycle.
      bus.wb_adr_i = 32'h8;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk($sformatf("b2b_ack%0d", k), bus.wb_ack_o, (k % 2 == 0) ? 1 : 0);
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      cyc(1);

      rd("rd_dir_rst", 3'd2, 32'hF0);
      rd("rd_out_rst", 3'd1, 32'h50);
      rd("rd_mask_rst", 3'd3, 32'h0);
      rd("rd_pend_rst", 3'd5, 32'h0);
      rd("rd_set_zero", 3'd6, 32'h0);
`ifndef WB_GPIO_DEBOUNCE_EN
      rd("rd_din_rst", 3'd0, 32'h50);
`endif

      wr("w_out", 3'd1, 32'h0000_00A5, 4'b0001);
      wr("w_set", 3'd6, 32'h0000_000A);
      wr("w_clr", 3'd7, 32'h0000_0001);
      rd("rd_out_ae", 3'd1, 32'hAE);
      chk("pins_ae", gpio[7:4], 4'hA);
      wr("w_sel0", 3'd1, 32'h0000_00FF, 4'b0000);
      rd("rd_out_sel0", 3'd1, 32'hAE);
      wr("w_upper", 3'd1, 32'hFFFF_FF00);
      rd("rd_out_upper", 3'd1, 32'h00);

      tb_en  = 8'hFF;
      tb_val = 8'h00;
      wr("w_dir0", 3'd2, 32'h0);
      cyc(SETTLE);
      wr("w_pclr", 3'd5, 32'hFF);
      rd("rd_pend_clr", 3'd5, 32'h0);

`ifdef WB_GPIO_DEBOUNCE_EN
      wr("w_edge4", 3'd4, 32'h04);
      wr("w_mask4", 3'd3, 32'h04);
      tb_val[2] = 1'b1;
      cyc(4);
      tb_val[2] = 1'b0;
      cyc(SETTLE);
      rd("db_din_glitch", 3'd0, 32'h00);
      rd("db_pend_glitch", 3'd5, 32'h00);
      chk("db_irq_glitch", irq, 0);
      tb_val[2] = 1'b1;
      cyc(SETTLE);
      rd("db_din_stable", 3'd0, 32'h04);
      rd("db_pend_stable", 3'd5, 32'h04);
      chk("db_irq_stable", irq, 1);
`else
      wr("w_edge1", 3'd4, 32'h01);
      wr("w_mask1", 3'd3, 32'h01);
      chk("irq_idle", irq, 0);
      tb_val[0] = 1'b1;
      cyc(SYNC + 1);
      chk("irq_lat_early", irq, 0);
      cyc(1);
      chk("irq_lat", irq, 1);
      rd("rd_pend_p0", 3'd5, 32'h01);
      rd("rd_din_p0", 3'd0, 32'h01);

      // Fresh rising edge lands in the same cycle as the W1C write.
      tb_val[0] = 1'b0;
      cyc(5);
      tb_val[0] = 1'b1;
      cyc(SYNC);
      wr("w_w1c_race", 3'd5, 32'h01);
      chk("irq_race", irq, 1);
      cyc(1);
      chk("irq_race2", irq, 1);
      rd("rd_pend_race", 3'd5, 32'h01);
      wr("w_w1c", 3'd5, 32'h01);
      chk("irq_w1c", irq, 0);
      rd("rd_pend_w1c", 3'd5, 32'h00);

      wr("w_mask0", 3'd3, 32'h00);
      wr("w_edge0", 3'd4, 32'h00);
      tb_val[3] = 1'b1;
      cyc(6);
      rd("rd_pend_rise_fe", 3'd5, 32'h00);
      tb_val[3] = 1'b0;
      cyc(6);
      rd("rd_pend_p3", 3'd5, 32'h08);
      chk("irq_masked", irq, 0);
      bus.wb_adr_i = {27'h0, 3'd3, 2'b00};
      bus.wb_dat_i = 32'h08;
      bus.wb_we_i  = 1'b1;
      bus.wb_sel_i = 4'b1111;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      cyc(1);
      chk("mask_ack", bus.wb_ack_o, 1);
      chk("irq_mask_same", irq, 0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      cyc(1);
      chk("irq_mask_next", irq, 1);

      // Output-direction bits must never raise PEND.
      wr("w_pclr2", 3'd5, 32'hFF);
      tb_en = 8'hEF;
      wr("w_dir10", 3'd2, 32'h10);
      wr("w_set10", 3'd6, 32'h10);
      cyc(6);
      rd("rd_din_out", 3'd0, 32'h11);
      wr("w_clr10", 3'd7, 32'h10);
      cyc(6);
      rd("rd_pend_out", 3'd5, 32'h00);
      chk("irq_out", irq, 0);
`endif

      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
